// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state type and per-opcode latency lookup for alu_op_sequencer.
// Float operands use 1 sign / 4 exponent (bias 7) / 7 mantissa bits; exponent 0 reads as zero.
package alu_seq_pkg;

    localparam logic [2:0] OP_ILL  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_UMUL = 3'b011;
    localparam logic [2:0] OP_SMUL = 3'b100;
    localparam logic [2:0] OP_FADD = 3'b101;
    localparam logic [2:0] OP_FMUL = 3'b110;
    localparam logic [2:0] OP_CMP  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic int unsigned lat_of(input logic [2:0] op,
                                           input int unsigned lat_add,
                                           input int unsigned lat_mul,
                                           input int unsigned lat_fadd,
                                           input int unsigned lat_fmul);
        case (op)
            OP_UMUL, OP_SMUL: return lat_mul;
            OP_FADD:          return lat_fadd;
            OP_FMUL:          return lat_fmul;
            default:          return lat_add;
        endcase
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational shared ALU: 8-bit add/sub/compare, 8x8 multiplies and 12-bit float add/multiply.
// Float results truncate toward zero; out-of-range magnitudes saturate to the largest finite value.
module alu_core
    import alu_seq_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [11:0] a,
    input  logic [11:0] b,
    output logic [15:0] result,
    output logic        flag,
    output logic        err
);

    logic [7:0]         add_sum;
    logic [7:0]         sub_diff;
    logic [15:0]        umul;
    logic signed [15:0] smul;
    logic               umul_ovf;
    logic               smul_ovf;

    assign add_sum  = a[7:0] + b[7:0];
    assign sub_diff = a[7:0] - b[7:0];
    assign umul     = a[7:0] * b[7:0];
    assign smul     = $signed(a[7:0]) * $signed(b[7:0]);
    assign umul_ovf = |umul[15:8];
    // Signed product fits in 8 bits only when bits 15..7 are a pure sign extension.
    assign smul_ovf = !((&smul[15:7]) || !(|smul[15:7]));

    // Float multiply: 8x8 mantissa product, normalised by at most one position.
    logic [15:0] fm_prod;
    logic [8:0]  fm_top;
    logic [5:0]  fm_esum;
    logic [11:0] fmul_z;
    logic        fmul_ovf;

    assign fm_prod = {1'b1, a[6:0]} * {1'b1, b[6:0]};
    assign fm_top  = 9'(fm_prod >> 7);
    assign fm_esum = {2'b00, a[10:7]} + {2'b00, b[10:7]} + {5'b0, fm_top[8]};

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        fmul_z   = '0;
        fmul_ovf = 1'b0;
        if (a[10:7] != 4'd0 && b[10:7] != 4'd0) begin
            if (fm_esum > 6'd22) begin
                fmul_z   = {a[11] ^ b[11], 4'hF, 7'h7F};
                fmul_ovf = 1'b1;
            end else if (fm_esum >= 6'd8) begin
                fmul_z = {a[11] ^ b[11], 4'(fm_esum - 6'd7),
                          fm_top[8] ? fm_top[7:1] : fm_top[6:0]};
            end
        end
    end

    // Float add: both operands aligned exactly into one fixed-point field, then renormalised.
    logic [21:0]        fa_mag_a;
    logic [21:0]        fa_mag_b;
    logic signed [23:0] fa_val_a;
    logic signed [23:0] fa_val_b;
    logic signed [23:0] fa_sum;
    logic [22:0]        fa_abs;
    logic [4:0]         fa_msb;
    logic [11:0]        fadd_z;

    assign fa_mag_a = (a[10:7] == 4'd0) ? '0 : (22'({1'b1, a[6:0]}) << (a[10:7] - 4'd1));
    assign fa_mag_b = (b[10:7] == 4'd0) ? '0 : (22'({1'b1, b[6:0]}) << (b[10:7] - 4'd1));
    assign fa_val_a = a[11] ? -$signed({2'b00, fa_mag_a}) : $signed({2'b00, fa_mag_a});
    assign fa_val_b = b[11] ? -$signed({2'b00, fa_mag_b}) : $signed({2'b00, fa_mag_b});
    assign fa_sum   = fa_val_a + fa_val_b;
    assign fa_abs   = fa_sum[23] ? 23'(-fa_sum) : 23'(fa_sum);

    always_comb begin
        fa_msb = '0;
        for (int i = 0; i < 23; i++) begin
            if (fa_abs[i]) fa_msb = 5'(i);
        end
    end

    always_comb begin
        fadd_z = '0;
        if (fa_abs != '0 && fa_msb >= 5'd7) begin
            if (fa_msb > 5'd21) fadd_z = {fa_sum[23], 4'hF, 7'h7F};
            else                fadd_z = {fa_sum[23], 4'(fa_msb - 5'd6), 7'(fa_abs >> (fa_msb - 5'd7))};
        end
    end

    always_comb begin
        result = '0;
        flag   = 1'b0;
        err    = 1'b0;
        case (op)
            OP_ADD:  result = {8'h00, add_sum};
            OP_SUB:  result = {8'h00, sub_diff};
            OP_UMUL: begin result = umul;          flag = umul_ovf; end
            OP_SMUL: begin result = smul;          flag = smul_ovf; end
            OP_FADD: result = {4'h0, fadd_z};
            OP_FMUL: begin result = {4'h0, fmul_z}; flag = fmul_ovf; end
            OP_CMP:  result = {4'h0, {12{a[7:0] != b[7:0]}}};
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle issue controller: holds operands stable for LAT(op) cycles around alu_core.
// Optional ALU_SEQ_PERF_EN adds saturating perf_ops / perf_busy counters.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned LAT_ADD  = 1,
    parameter int unsigned LAT_MUL  = 2,
    parameter int unsigned LAT_FADD = 3,
    parameter int unsigned LAT_FMUL = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [11:0] req_a,
    input  logic [11:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_flag,
    output logic        rsp_err
`ifdef ALU_SEQ_PERF_EN
    ,
    output logic [15:0] perf_ops,
    output logic [15:0] perf_busy
`endif
);

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  cnt;
    logic [2:0]  op_q;
    logic [11:0] a_q;
    logic [11:0] b_q;
    logic [15:0] alu_result;
    logic        alu_flag;
    logic        alu_err;
    logic        req_fire;
    logic        exec_last;

    alu_core u_alu_core (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_result),
        .flag   (alu_flag),
        .err    (alu_err)
    );

    assign req_fire  = req_valid && req_ready;
    assign exec_last = (state == EXEC) && (cnt == 3'd0);

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = EXEC;
            end
            EXEC: if (cnt == 3'd0) state_nxt = DONE;
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: reset is synchronous and clears operands too, so an aborted op leaves nothing behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rsp_result <= '0;
            rsp_flag   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (req_fire) begin
                op_q <= req_op;
                a_q  <= req_a;
                b_q  <= req_b;
                cnt  <= 3'(lat_of(req_op, LAT_ADD, LAT_MUL, LAT_FADD, LAT_FMUL) - 1);
            end else if (state == EXEC && cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
            if (exec_last) begin
                rsp_result <= alu_result;
                rsp_flag   <= alu_flag;
                rsp_err    <= alu_err;
            end
        end
    end

`ifdef ALU_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ops  <= '0;
            perf_busy <= '0;
        end else begin
            if (rsp_valid && rsp_ready && perf_ops != 16'hFFFF) perf_ops <= perf_ops + 16'd1;
            if (state == EXEC && perf_busy != 16'hFFFF) perf_busy <= perf_busy + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomised bench for alu_op_sequencer against a value-level model (integers and reals).
// Define ALU_SEQ_PERF_EN for both RTL and bench to also check the perf counters.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [11:0] req_a;
    logic [11:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_flag;
    logic        rsp_err;
`ifdef ALU_SEQ_PERF_EN
    logic [15:0] perf_ops;
    logic [15:0] perf_busy;
`endif

    int n_vec = 0;
    int n_err = 0;
    int exp_ops = 0;
    int exp_busy = 0;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flag   (rsp_flag),
        .rsp_err    (rsp_err)
`ifdef ALU_SEQ_PERF_EN
        ,
        .perf_ops   (perf_ops),
        .perf_busy  (perf_busy)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int lat(input int op);
        case (op)
            3, 4:    return 2;
            5:       return 3;
            6:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic real fp_dec(input logic [11:0] x);
        real m;
        int  e;
        e = int'(x[10:7]);
        if (e == 0) return 0.0;
        m = (1.0 + real'(int'(x[6:0])) / 128.0) * (2.0 ** (e - 7));
        return x[11] ? -m : m;
    endfunction

    // Truncate toward zero; below the smallest normal flushes to 0, above the largest saturates.
    task automatic fp_enc(input real v, output logic [11:0] z, output logic ovf);
        real m;
        int  e;
        logic s;
        z   = '0;
        ovf = 1'b0;
        if (v == 0.0) return;
        s = (v < 0.0);
        m = s ? -v : v;
        e = 7;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        if (e > 15) begin
            z   = {s, 4'hF, 7'h7F};
            ovf = 1'b1;
        end else if (e >= 1) begin
            z = {s, 4'(e), 7'($rtoi((m - 1.0) * 128.0))};
        end
    endtask

    task automatic model(input int op, input logic [11:0] a, input logic [11:0] b,
                         output logic [15:0] r, output logic f, output logic e);
        int ia, ib, sa, sb, p;
        logic [11:0] z;
        logic o;
        ia = int'(a[7:0]);
        ib = int'(b[7:0]);
        sa = (ia >= 128) ? ia - 256 : ia;
        sb = (ib >= 128) ? ib - 256 : ib;
        r = '0; f = 1'b0; e = 1'b0;
        case (op)
            0: e = 1'b1;
            1: r = 16'((ia + ib) % 256);
            2: r = 16'((ia - ib + 256) % 256);
            3: begin p = ia * ib; r = 16'(p); f = (p > 255); end
            4: begin p = sa * sb; r = 16'(p); f = (p > 127) || (p < -128); end
            5: begin fp_enc(fp_dec(a) + fp_dec(b), z, o); r = {4'h0, z}; end
            6: begin fp_enc(fp_dec(a) * fp_dec(b), z, o); r = {4'h0, z}; f = o; end
            default: r = (ia != ib) ? 16'h0FFF : 16'h0000;
        endcase
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_ops  = 0;
        exp_busy = 0;
    endtask

    task automatic run_op(input int op, input logic [11:0] a, input logic [11:0] b, input int bp);
        logic [15:0] er;
        logic ef, ee;
        int k;
        model(op, a, b, er, ef, ee);
        check("ready_idle", req_ready, 1);
        req_valid = 1'b1; req_op = 3'(op); req_a = a; req_b = b;
        @(posedge clk); #1;
        req_valid = 1'b0; req_a = $urandom; req_b = $urandom;
        rsp_ready = 1'($urandom_range(0, 1));
        check("ready_busy", req_ready, 0);
        k = 1;
        while (!rsp_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check($sformatf("latency_op%0d", op), k, lat(op) + 1);
        if (!rsp_valid) begin
            rsp_ready = 1'b0;
            pulse_reset();
            return;
        end
        check("ready_in_done", req_ready, 0);
        check($sformatf("result_op%0d", op), rsp_result, er);
        check($sformatf("flag_op%0d", op), rsp_flag, ef);
        check($sformatf("err_op%0d", op), rsp_err, ee);
        rsp_ready = 1'b0;
        repeat (bp) begin @(posedge clk); #1; end
        if (bp > 0) check("held_rsp", {rsp_valid, req_ready, rsp_flag, rsp_err, rsp_result},
                          {1'b1, 1'b0, ef, ee, er});
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("released", {rsp_valid, req_ready}, 2'b01);
        exp_ops++;
        exp_busy += lat(op);
`ifdef ALU_SEQ_PERF_EN
        check("perf_ops", perf_ops, exp_ops);
        check("perf_busy", perf_busy, exp_busy);
`endif
    endtask

    initial begin
        int seen;
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_state", {req_ready, rsp_valid, rsp_flag, rsp_err, rsp_result},
              {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
`ifdef ALU_SEQ_PERF_EN
        check("reset_perf", {perf_ops, perf_busy}, 32'h0);
`endif

        run_op(1, 12'h03C, 12'h005, 0);
        run_op(2, 12'h005, 12'h007, 0);
        run_op(3, 12'h0FF, 12'h0FF, 0);
        run_op(6, 12'h3C0, 12'h3C0, 0);
        run_op(1, 12'h0AA, 12'h011, 10);

        // Abort an fmul two cycles into EXEC.
        req_valid = 1'b1; req_op = 3'd6; req_a = 12'h3C0; req_b = 12'h3C0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        pulse_reset();
        check("abort_state", {req_ready, rsp_valid}, 2'b10);
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        rsp_ready = 1'b0;
        check("abort_no_rsp", seen, 0);

        run_op(0, 12'h123, 12'h456, 0);

        for (int i = 0; i < 40; i++) begin
            int op;
            op = $urandom_range(0, 7);
            if (i % 8 == 0) run_op(op, 12'($urandom), 12'($urandom & 32'h0FF), $urandom_range(0, 3));
            else            run_op(op, 12'($urandom), 12'($urandom), $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
